// File: rtl/tank_life_ctrl.sv
// Per-tank lifecycle sequencer: turns a hit strobe into the timed
// explosion -> respawn pulse -> spawn-shield sequence and tracks remaining lives.
module tank_life_ctrl #(
    parameter logic [31:0] BURST_CYCLES  = 32'h3000000,
    parameter logic [31:0] RESET_PULSE   = 32'd16,
    parameter logic [31:0] INVULN_CYCLES = 32'h1000000,
    parameter logic [2:0]  LIVES         = 3'd3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tank_hit,
    input  logic       restart,
    output logic       burst,
    output logic       tank_reset,
    output logic       invuln,
    output logic       game_over,
    output logic [2:0] lives,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ALIVE   = 3'd0,
        BURST   = 3'd1,
        RESPAWN = 3'd2,
        SHIELD  = 3'd3,
        DEAD    = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [2:0]  lives_q, lives_d;
    logic        burst_q, tank_reset_q, invuln_q, game_over_q;

    // Each timed phase counts from zero; every transition clears the counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 32'd1;
        lives_d = lives_q;
        if (restart) begin
            state_d = ALIVE;
            cnt_d   = 32'd0;
            lives_d = LIVES;
        end else begin
            case (state_q)
                ALIVE: begin
                    cnt_d = 32'd0;
                    if (tank_hit) begin
                        state_d = BURST;
                        lives_d = lives_q - 3'd1;
                    end
                end
                BURST: begin
                    if (cnt_q == BURST_CYCLES - 32'd1) begin
                        cnt_d   = 32'd0;
                        state_d = (lives_q == 3'd0) ? DEAD : RESPAWN;
                    end
                end
                RESPAWN: begin
                    if (cnt_q == RESET_PULSE - 32'd1) begin
                        cnt_d   = 32'd0;
                        state_d = SHIELD;
                    end
                end
                SHIELD: begin
                    if (cnt_q == INVULN_CYCLES - 32'd1) begin
                        cnt_d   = 32'd0;
                        state_d = ALIVE;
                    end
                end
                DEAD: begin
                    cnt_d = 32'd0;
                end
                default: begin
                    state_d = ALIVE;
                    cnt_d   = 32'd0;
                end
            endcase
        end
    end

    // Flags are decoded from the next state so they move on the same edge as state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ALIVE;
            cnt_q        <= 32'd0;
            lives_q      <= LIVES;
            burst_q      <= 1'b0;
            tank_reset_q <= 1'b0;
            invuln_q     <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            lives_q      <= lives_d;
            burst_q      <= (state_d == BURST);
            tank_reset_q <= (state_d == RESPAWN);
            invuln_q     <= (state_d == SHIELD);
            game_over_q  <= (state_d == DEAD);
        end
    end

    assign burst      = burst_q;
    assign tank_reset = tank_reset_q;
    assign invuln     = invuln_q;
    assign game_over  = game_over_q;
    assign lives      = lives_q;
    assign state      = state_q;

endmodule
